// File: rtl/spi_data_buffer_pkg.sv
// Shared constants, FIFO status record and the frame length/bit-order formatter
// for the SPI data path.
package spi_data_buffer_pkg;

    localparam int unsigned SPI_DATA_W     = 32;
    localparam int unsigned SPI_FIFO_DEPTH = 8;
    localparam int unsigned SPI_CNT_W      = 7;

    typedef enum logic {
        SPI_MSB_FIRST = 1'b0,
        SPI_LSB_FIRST = 1'b1
    } spi_dord_e;

    typedef struct packed {
        logic                 empty;
        logic                 full;
        logic [SPI_CNT_W-1:0] count;
    } spi_fifo_stat_t;

    // Keeps bits [len:0] (reversed within that field when LSB first); upper bits cleared.
    function automatic logic [SPI_DATA_W-1:0] spi_fmt(input logic [SPI_DATA_W-1:0] word,
                                                      input logic [4:0]            len,
                                                      input logic                  dord);
        logic [SPI_DATA_W-1:0] res;
        logic [4:0]            src;
        res = '0;
        for (int unsigned i = 0; i < SPI_DATA_W; i++) begin
            if (i <= 32'(len)) begin
                src = (dord == SPI_LSB_FIRST) ? 5'(32'(len) - i) : 5'(i);
                res[5'(i)] = word[src];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/spi_data_buffer_fifo.sv
// Synchronous FIFO with registered read data; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module spi_sync_fifo
    import spi_data_buffer_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wen,
    input  logic              ren,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output spi_fifo_stat_t    stat,
    output logic              push_drop,
    output logic              pop_drop
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic              empty;
    logic              full;
    logic              push;
    logic              pop;

    assign empty     = (count == '0);
    assign full      = (count == (PTR_W+1)'(DEPTH));
    assign push      = wen & (~full | ren);
    assign pop       = ren & ~empty;
    assign push_drop = wen & ~push;
    assign pop_drop  = ren & ~pop;

    assign stat.empty = empty;
    assign stat.full  = full;
    assign stat.count = SPI_CNT_W'(count);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                dout   <= mem[rd_ptr];
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/spi_data_buffer.sv
// SPI TX/RX data buffer: two FIFOs, frame formatting, sticky errors and irqs.
// Define SPI_DATA_THRESH_EN for registered threshold-based interrupts.
module spi_data_buffer
    import spi_data_buffer_pkg::*;
#(
    parameter int unsigned DATA_W = SPI_DATA_W,
    parameter int unsigned DEPTH  = SPI_FIFO_DEPTH,
    parameter int unsigned PTR_W  = $clog2(DEPTH),
    parameter int unsigned LEN_W  = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] wdata,
    input  logic              tfifo_wen,
    input  logic              tfifo_ren,
    input  logic              rfifo_wen,
    input  logic              rfifo_ren,
    input  logic [DATA_W-1:0] receive_data,
    input  logic              dord,
    input  logic [LEN_W-1:0]  datalen,
    input  logic              err_clr,
    input  logic [PTR_W:0]    tfifo_thresh,
    input  logic [PTR_W:0]    rfifo_thresh,
    output logic [DATA_W-1:0] transfer_data,
    output logic [DATA_W-1:0] rfifo_out,
    output logic [PTR_W:0]    tfifo_status,
    output logic [PTR_W:0]    rfifo_status,
    output logic              tfifo_empty,
    output logic              tfifo_full,
    output logic              rfifo_empty,
    output logic              rfifo_full,
    output logic              tfifo_udr,
    output logic              rfifo_ovr,
    output logic              tfifo_irq,
    output logic              rfifo_irq
);

    spi_fifo_stat_t    tx_stat;
    spi_fifo_stat_t    rx_stat;
    logic [DATA_W-1:0] tx_dout;
    logic [DATA_W-1:0] rx_din;
    logic              tx_push_drop;
    logic              tx_pop_drop;
    logic              rx_push_drop;
    logic              rx_pop_drop;
    logic [LEN_W-1:0]  tx_len_q;
    logic              tx_dord_q;
    logic              unused_bits;

    assign unused_bits = ^{tx_stat.count, rx_stat.count, tx_push_drop, rx_pop_drop};

    assign rx_din = DATA_W'(spi_fmt(SPI_DATA_W'(receive_data), 5'(datalen), dord));

    spi_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .wen       (tfifo_wen),
        .ren       (tfifo_ren),
        .din       (wdata),
        .dout      (tx_dout),
        .stat      (tx_stat),
        .push_drop (tx_push_drop),
        .pop_drop  (tx_pop_drop)
    );

    spi_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .wen       (rfifo_wen),
        .ren       (rfifo_ren),
        .din       (rx_din),
        .dout      (rfifo_out),
        .stat      (rx_stat),
        .push_drop (rx_push_drop),
        .pop_drop  (rx_pop_drop)
    );

    assign tfifo_status = tx_stat.count[PTR_W:0];
    assign rfifo_status = rx_stat.count[PTR_W:0];
    assign tfifo_empty  = tx_stat.empty;
    assign tfifo_full   = tx_stat.full;
    assign rfifo_empty  = rx_stat.empty;
    assign rfifo_full   = rx_stat.full;

    // TX words are stored raw; format settings are captured on the pop edge so
    // the held output keeps the formatting it was popped with.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_len_q  <= '0;
            tx_dord_q <= 1'b0;
        end else if (tfifo_ren && !tx_stat.empty) begin
            tx_len_q  <= datalen;
            tx_dord_q <= dord;
        end
    end

    assign transfer_data = DATA_W'(spi_fmt(SPI_DATA_W'(tx_dout), 5'(tx_len_q), tx_dord_q));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tfifo_udr <= 1'b0;
            rfifo_ovr <= 1'b0;
        end else begin
            if (err_clr) begin
                tfifo_udr <= 1'b0;
                rfifo_ovr <= 1'b0;
            end else begin
                if (tx_pop_drop) tfifo_udr <= 1'b1;
                if (rx_push_drop) rfifo_ovr <= 1'b1;
            end
        end
    end

`ifdef SPI_DATA_THRESH_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tfifo_irq <= 1'b0;
            rfifo_irq <= 1'b0;
        end else begin
            tfifo_irq <= (tfifo_status <= tfifo_thresh);
            rfifo_irq <= (rfifo_status >= rfifo_thresh) | rfifo_ovr;
        end
    end
`else
    logic unused_thresh;
    assign unused_thresh = ^{tfifo_thresh, rfifo_thresh};
    assign tfifo_irq     = tx_stat.empty;
    assign rfifo_irq     = ~rx_stat.empty | rfifo_ovr;
`endif

endmodule

// File: tb/tb_spi_data_buffer.sv
// Self-checking bench for spi_data_buffer (DATA_W=32, DEPTH=8, default build).
module tb_spi_data_buffer;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned PTR_W  = 3;
    localparam int unsigned LEN_W  = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DATA_W-1:0] wdata = '0;
    logic              tfifo_wen = 1'b0;
    logic              tfifo_ren = 1'b0;
    logic              rfifo_wen = 1'b0;
    logic              rfifo_ren = 1'b0;
    logic [DATA_W-1:0] receive_data = '0;
    logic              dord = 1'b0;
    logic [LEN_W-1:0]  datalen = '0;
    logic              err_clr = 1'b0;
    logic [PTR_W:0]    tfifo_thresh = 4'd2;
    logic [PTR_W:0]    rfifo_thresh = 4'd6;
    logic [DATA_W-1:0] transfer_data;
    logic [DATA_W-1:0] rfifo_out;
    logic [PTR_W:0]    tfifo_status;
    logic [PTR_W:0]    rfifo_status;
    logic              tfifo_empty, tfifo_full, rfifo_empty, rfifo_full;
    logic              tfifo_udr, rfifo_ovr, tfifo_irq, rfifo_irq;

    spi_data_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .wdata         (wdata),
        .tfifo_wen     (tfifo_wen),
        .tfifo_ren     (tfifo_ren),
        .rfifo_wen     (rfifo_wen),
        .rfifo_ren     (rfifo_ren),
        .receive_data  (receive_data),
        .dord          (dord),
        .datalen       (datalen),
        .err_clr       (err_clr),
        .tfifo_thresh  (tfifo_thresh),
        .rfifo_thresh  (rfifo_thresh),
        .transfer_data (transfer_data),
        .rfifo_out     (rfifo_out),
        .tfifo_status  (tfifo_status),
        .rfifo_status  (rfifo_status),
        .tfifo_empty   (tfifo_empty),
        .tfifo_full    (tfifo_full),
        .rfifo_empty   (rfifo_empty),
        .rfifo_full    (rfifo_full),
        .tfifo_udr     (tfifo_udr),
        .rfifo_ovr     (rfifo_ovr),
        .tfifo_irq     (tfifo_irq),
        .rfifo_irq     (rfifo_irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_rx;
        logic        d;
        logic [4:0]  len;
        logic [31:0] word;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs [9];
    logic [31:0] tx_q [$];
    logic [31:0] rx_q [$];
    logic [31:0] last_tx;
    logic [31:0] last_rx;
    int          checks = 0;
    int          errors = 0;

    // Mask to the low len+1 bits, then mirror that field when LSB first.
    function automatic logic [31:0] model_fmt(input logic [31:0] w, input int unsigned len,
                                              input logic d);
        logic [31:0] m;
        logic [31:0] r;
        m = (len >= 31) ? w : (w & ((32'd1 << (len + 1)) - 32'd1));
        if (!d) return m;
        r = '0;
        for (int unsigned j = 0; j <= len; j++) r[len - j] = m[j];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        tfifo_wen = 1'b0;
        tfifo_ren = 1'b0;
        rfifo_wen = 1'b0;
        rfifo_ren = 1'b0;
        err_clr   = 1'b0;
    endtask

    task automatic tx_push(input logic [31:0] w);
        wdata     = w;
        tfifo_wen = 1'b1;
        if (tx_q.size() < DEPTH) tx_q.push_back(w);
        tick();
    endtask

    task automatic tx_pop_expect(input string name);
        logic [31:0] e;
        e         = model_fmt(tx_q.pop_front(), int'(datalen), dord);
        tfifo_ren = 1'b1;
        tick();
        last_tx = e;
        check(name, transfer_data, e);
    endtask

    task automatic rx_push(input logic [31:0] w);
        receive_data = w;
        rfifo_wen    = 1'b1;
        if (rx_q.size() < DEPTH) rx_q.push_back(model_fmt(w, int'(datalen), dord));
        tick();
    endtask

    task automatic rx_pop_expect(input string name);
        logic [31:0] e;
        e         = rx_q.pop_front();
        rfifo_ren = 1'b1;
        tick();
        last_rx = e;
        check(name, rfifo_out, e);
    endtask

    initial begin
        logic [31:0] w;
        logic [31:0] e;

        vecs[0] = '{1'b0, 1'b0, 5'd3,  32'hFFFF_FFF5, 32'h0000_0005};
        vecs[1] = '{1'b0, 1'b1, 5'd7,  32'h0000_0013, 32'h0000_00C8};
        vecs[2] = '{1'b0, 1'b0, 5'd31, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[3] = '{1'b0, 1'b1, 5'd31, 32'h0000_0001, 32'h8000_0000};
        vecs[4] = '{1'b0, 1'b1, 5'd3,  32'h0000_0001, 32'h0000_0008};
        vecs[5] = '{1'b0, 1'b0, 5'd0,  32'h0000_00FF, 32'h0000_0001};
        vecs[6] = '{1'b0, 1'b1, 5'd15, 32'hFF00_00F1, 32'h0000_8F00};
        vecs[7] = '{1'b1, 1'b0, 5'd3,  32'hF000_000E, 32'h0000_000E};
        vecs[8] = '{1'b1, 1'b1, 5'd3,  32'hF000_000E, 32'h0000_0007};

        #12;
        check("rst tx_status", 32'(tfifo_status), 32'd0);
        check("rst rx_status", 32'(rfifo_status), 32'd0);
        check("rst empties", {30'd0, tfifo_empty, rfifo_empty}, 32'd3);
        check("rst fulls", {30'd0, tfifo_full, rfifo_full}, 32'd0);
        check("rst transfer_data", transfer_data, 32'd0);
        check("rst rfifo_out", rfifo_out, 32'd0);
        check("rst errors", {30'd0, tfifo_udr, rfifo_ovr}, 32'd0);
        check("rst rfifo_irq", 32'(rfifo_irq), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            dord    = vecs[i].d;
            datalen = vecs[i].len;
            if (vecs[i].is_rx) begin
                receive_data = vecs[i].word;
                rfifo_wen    = 1'b1;
                tick();
                rfifo_ren = 1'b1;
                tick();
                check($sformatf("vec%0d rx", i), rfifo_out, vecs[i].exp);
            end else begin
                wdata     = vecs[i].word;
                tfifo_wen = 1'b1;
                tick();
                tfifo_ren = 1'b1;
                tick();
                check($sformatf("vec%0d tx", i), transfer_data, vecs[i].exp);
            end
        end

        // Fill, overfill, drain with 4-bit MSB-first frames.
        dord    = 1'b0;
        datalen = 5'd3;
        for (int i = 0; i < 8; i++) tx_push(32'(i));
        check("fill full", 32'(tfifo_full), 32'd1);
        check("fill status", 32'(tfifo_status), 32'd8);
        tx_push(32'h8);
        check("overfill status", 32'(tfifo_status), 32'd8);
        check("overfill tx_irq", 32'(tfifo_irq), 32'd0);
        check("overfill no udr", 32'(tfifo_udr), 32'd0);
        for (int i = 0; i < 8; i++) tx_pop_expect($sformatf("drain%0d", i));
        check("drained empty", 32'(tfifo_empty), 32'd1);
        check("drained tx_irq", 32'(tfifo_irq), 32'd1);

        // Underrun leaves pointers and output alone.
        tfifo_ren = 1'b1;
        tick();
        check("udr set", 32'(tfifo_udr), 32'd1);
        check("udr status", 32'(tfifo_status), 32'd0);
        check("udr held", transfer_data, 32'h7);
        tx_push(32'hA);
        tx_pop_expect("after udr");
        check("udr sticky", 32'(tfifo_udr), 32'd1);
        err_clr = 1'b1;
        tick();
        check("udr clr", 32'(tfifo_udr), 32'd0);

        // Full + push + pop keeps count and ordering.
        datalen = 5'd31;
        for (int i = 0; i < 8; i++) tx_push($urandom());
        w         = $urandom();
        e         = model_fmt(tx_q.pop_front(), 31, 1'b0);
        tx_q.push_back(w);
        wdata     = w;
        tfifo_wen = 1'b1;
        tfifo_ren = 1'b1;
        tick();
        last_tx = e;
        check("full push+pop data", transfer_data, e);
        check("full push+pop status", 32'(tfifo_status), 32'd8);
        for (int i = 0; i < 8; i++) tx_pop_expect($sformatf("order%0d", i));

        // Empty + push + pop: no bypass, underrun flagged.
        tx_q.push_back(32'h1234_5678);
        wdata     = 32'h1234_5678;
        tfifo_wen = 1'b1;
        tfifo_ren = 1'b1;
        tick();
        check("empty push+pop udr", 32'(tfifo_udr), 32'd1);
        check("empty push+pop held", transfer_data, last_tx);
        check("empty push+pop status", 32'(tfifo_status), 32'd1);
        tx_pop_expect("empty push+pop word");
        err_clr = 1'b1;
        tick();

        // RX overflow and clear-wins.
        for (int i = 0; i < 8; i++) rx_push($urandom());
        check("rx full", 32'(rfifo_full), 32'd1);
        check("rx irq level", 32'(rfifo_irq), 32'd1);
        check("rx ovr clear", 32'(rfifo_ovr), 32'd0);
        rx_push(32'h5555_AAAA);
        check("rx ovr set", 32'(rfifo_ovr), 32'd1);
        check("rx ovr status", 32'(rfifo_status), 32'd8);
        receive_data = 32'h0F0F_0F0F;
        rfifo_wen    = 1'b1;
        err_clr      = 1'b1;
        tick();
        check("rx clr wins", 32'(rfifo_ovr), 32'd0);
        for (int i = 0; i < 8; i++) rx_pop_expect($sformatf("rx drain%0d", i));
        check("rx empty", 32'(rfifo_empty), 32'd1);
        check("rx irq idle", 32'(rfifo_irq), 32'd0);
        rfifo_ren = 1'b1;
        tick();
        check("rx pop empty held", rfifo_out, last_rx);
        check("rx pop empty no err", {30'd0, rfifo_ovr, tfifo_udr}, 32'd0);

        // Asynchronous reset in the middle of a burst.
        for (int i = 0; i < 6; i++) tx_push(32'h100 + 32'(i));
        rx_push(32'hCAFE_F00D);
        rx_pop_expect("pre-rst rx");
        tx_pop_expect("pre-rst tx");
        check("pre-rst status", 32'(tfifo_status), 32'd5);
        #3;
        rst = 1'b1;
        #1;
        check("async rst status", 32'(tfifo_status), 32'd0);
        check("async rst tx data", transfer_data, 32'd0);
        check("async rst rx data", rfifo_out, 32'd0);
        check("async rst empty", 32'(tfifo_empty), 32'd1);
        tx_q.delete();
        rx_q.delete();
        @(negedge clk);
        rst = 1'b0;
        tx_push(32'h77);
        tx_pop_expect("post-rst tx");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
